// File: rtl/lcd_ctrl_param.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_param
//
// Parametrised image-buffer controller. It loads an IMG_W x IMG_H grey-level
// frame from IROM into an internal pixel buffer. It then applies host commands
// to a 2x2 window around a movable operation point. On a Write command it
// streams the whole buffer out to IRAM.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset
//   cmd         in   4      command code, sampled when cmd_valid && !busy
//   cmd_valid   in   1      command present
//   IROM_Q      in   PIX_W  ROM data, valid one cycle after IROM_A
//   IROM_rd     out  1      ROM read enable
//   IROM_A      out  AW     ROM address
//   IRAM_valid  out  1      IRAM_D / IRAM_A valid this cycle
//   IRAM_D      out  PIX_W  pixel written to IRAM
//   IRAM_A      out  AW     IRAM address
//   busy        out  1      1 = host must not issue a command
//   done        out  1      one-cycle pulse when a frame write completes
//
// Command codes
//   0 write frame, 1 up, 2 down, 3 left, 4 right, 5 max, 6 min, 7 average,
//   8 rotate CCW, 9 rotate CW, 10 mirror-X (swap rows),
//   11 mirror-Y (swap columns), 12..15 no-op (still one busy cycle)
// -----------------------------------------------------------------------------
module lcd_ctrl_param #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [PIX_W-1:0] IROM_Q,
    output logic             IROM_rd,
    output logic [AW-1:0]    IROM_A,
    output logic             IRAM_valid,
    output logic [PIX_W-1:0] IRAM_D,
    output logic [AW-1:0]    IRAM_A,
    output logic             busy,
    output logic             done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int N  = IMG_W * IMG_H;

    localparam logic [AW-1:0] LAST_A = AW'(N - 1);
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_INIT = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_INIT = YW'(IMG_H / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMD,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ROM fetch side
    logic             r_irom_rd;
    logic [AW-1:0]    r_irom_a;
    // Address whose ROM data arrives this cycle
    logic             r_cap_vld;
    logic [AW-1:0]    r_cap_a;

    // IRAM stream side
    logic             r_iram_valid;
    logic [AW-1:0]    r_iram_a;
    logic [PIX_W-1:0] r_iram_d;
    logic [AW-1:0]    w_iram_a_next;

    // Operation point
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;

    // Pixel buffer. It is a register array, not block RAM, because a window
    // command reads and writes four entries on the same edge.
    logic [PIX_W-1:0] r_pix [N];

    logic             w_busy;
    logic             w_accept;
    logic             w_load_last;

    // Window addresses and pre-edge values
    logic [XW-1:0]    w_xm1;
    logic [YW-1:0]    w_ym1;
    logic [AW-1:0]    w_idx_lu;
    logic [AW-1:0]    w_idx_ru;
    logic [AW-1:0]    w_idx_ld;
    logic [AW-1:0]    w_idx_rd;
    logic [PIX_W-1:0] w_p_lu;
    logic [PIX_W-1:0] w_p_ru;
    logic [PIX_W-1:0] w_p_ld;
    logic [PIX_W-1:0] w_p_rd;

    // Window arithmetic
    logic [PIX_W-1:0] w_max_top;
    logic [PIX_W-1:0] w_max_bot;
    logic [PIX_W-1:0] w_max;
    logic [PIX_W-1:0] w_min_top;
    logic [PIX_W-1:0] w_min_bot;
    logic [PIX_W-1:0] w_min;
    logic [PIX_W+1:0] w_sum;
    logic [PIX_W-1:0] w_avg;

    // New window values
    logic [PIX_W-1:0] w_n_lu;
    logic [PIX_W-1:0] w_n_ru;
    logic [PIX_W-1:0] w_n_ld;
    logic [PIX_W-1:0] w_n_rd;
    logic             w_win_we;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // DONE behaves like CMD for the host, so a command offered in the
    // done-pulse cycle is taken.
    assign w_busy   = !((r_state == S_CMD) || (r_state == S_DONE));
    assign w_accept = cmd_valid && !w_busy;

    // The last capture is one cycle after the last address is issued,
    // because the ROM answers one cycle late.
    assign w_load_last = (r_state == S_LOAD) && r_cap_vld && (r_cap_a == LAST_A);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = S_LOAD;
            S_LOAD: begin
                if (w_load_last) begin
                    w_state_next = S_CMD;
                end
            end
            S_CMD, S_DONE: begin
                if (w_accept) begin
                    w_state_next = (cmd == 4'd0) ? S_WRITE : S_EXEC;
                end else begin
                    w_state_next = S_CMD;
                end
            end
            S_EXEC: w_state_next = S_CMD;
            S_WRITE: begin
                if (r_iram_a == LAST_A) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Window addressing. The image sizes are powers of two, so the row-major
    // index y*IMG_W + x is simply {y, x}.
    // -------------------------------------------------------------------------
    assign w_xm1    = r_x - X_ONE;
    assign w_ym1    = r_y - Y_ONE;
    assign w_idx_lu = AW'({w_ym1, w_xm1});
    assign w_idx_ru = AW'({w_ym1, r_x});
    assign w_idx_ld = AW'({r_y, w_xm1});
    assign w_idx_rd = AW'({r_y, r_x});

    assign w_p_lu = r_pix[w_idx_lu];
    assign w_p_ru = r_pix[w_idx_ru];
    assign w_p_ld = r_pix[w_idx_ld];
    assign w_p_rd = r_pix[w_idx_rd];

    assign w_max_top = (w_p_lu > w_p_ru) ? w_p_lu : w_p_ru;
    assign w_max_bot = (w_p_ld > w_p_rd) ? w_p_ld : w_p_rd;
    assign w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
    assign w_min_top = (w_p_lu < w_p_ru) ? w_p_lu : w_p_ru;
    assign w_min_bot = (w_p_ld < w_p_rd) ? w_p_ld : w_p_rd;
    assign w_min     = (w_min_top < w_min_bot) ? w_min_top : w_min_bot;

    // Two extra bits hold the sum of four pixels without overflow.
    // Dropping the two LSBs gives floor(sum/4).
    assign w_sum = {2'b00, w_p_lu} + {2'b00, w_p_ru} + {2'b00, w_p_ld} + {2'b00, w_p_rd};
    assign w_avg = w_sum[PIX_W+1:2];

    always_comb begin
        w_n_lu   = w_p_lu;
        w_n_ru   = w_p_ru;
        w_n_ld   = w_p_ld;
        w_n_rd   = w_p_rd;
        w_win_we = 1'b0;
        if (w_accept) begin
            case (cmd)
                4'd5: begin
                    w_n_lu   = w_max;
                    w_n_ru   = w_max;
                    w_n_ld   = w_max;
                    w_n_rd   = w_max;
                    w_win_we = 1'b1;
                end
                4'd6: begin
                    w_n_lu   = w_min;
                    w_n_ru   = w_min;
                    w_n_ld   = w_min;
                    w_n_rd   = w_min;
                    w_win_we = 1'b1;
                end
                4'd7: begin
                    w_n_lu   = w_avg;
                    w_n_ru   = w_avg;
                    w_n_ld   = w_avg;
                    w_n_rd   = w_avg;
                    w_win_we = 1'b1;
                end
                4'd8: begin // counter-clockwise
                    w_n_lu   = w_p_ru;
                    w_n_ld   = w_p_lu;
                    w_n_rd   = w_p_ld;
                    w_n_ru   = w_p_rd;
                    w_win_we = 1'b1;
                end
                4'd9: begin // clockwise
                    w_n_ru   = w_p_lu;
                    w_n_rd   = w_p_ru;
                    w_n_ld   = w_p_rd;
                    w_n_lu   = w_p_ld;
                    w_win_we = 1'b1;
                end
                4'd10: begin // swap rows
                    w_n_lu   = w_p_ld;
                    w_n_ld   = w_p_lu;
                    w_n_ru   = w_p_rd;
                    w_n_rd   = w_p_ru;
                    w_win_we = 1'b1;
                end
                4'd11: begin // swap columns
                    w_n_lu   = w_p_ru;
                    w_n_ru   = w_p_lu;
                    w_n_ld   = w_p_rd;
                    w_n_rd   = w_p_ld;
                    w_win_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pixel buffer writes: ROM capture during LOAD and window updates on an
    // accepted command. These two never happen in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == S_LOAD) && r_cap_vld) begin
            r_pix[r_cap_a] <= IROM_Q;
        end
        if (w_win_we) begin
            r_pix[w_idx_lu] <= w_n_lu;
            r_pix[w_idx_ru] <= w_n_ru;
            r_pix[w_idx_ld] <= w_n_ld;
            r_pix[w_idx_rd] <= w_n_rd;
        end
    end

    // -------------------------------------------------------------------------
    // Operation point. Moves saturate at the legal window range.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= X_INIT;
            r_y <= Y_INIT;
        end else if (w_accept) begin
            case (cmd)
                4'd1: if (r_y != Y_ONE) r_y <= r_y - Y_ONE;
                4'd2: if (r_y != Y_MAX) r_y <= r_y + Y_ONE;
                4'd3: if (r_x != X_ONE) r_x <= r_x - X_ONE;
                4'd4: if (r_x != X_MAX) r_x <= r_x + X_ONE;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // ROM fetch sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irom_rd <= 1'b0;
            r_irom_a  <= '0;
            r_cap_vld <= 1'b0;
            r_cap_a   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Every frame load starts again from address 0
                    r_irom_rd <= 1'b1;
                    r_irom_a  <= '0;
                    r_cap_vld <= 1'b0;
                end
                S_LOAD: begin
                    r_cap_vld <= r_irom_rd;
                    r_cap_a   <= r_irom_a;
                    if (r_irom_rd) begin
                        if (r_irom_a == LAST_A) begin
                            r_irom_rd <= 1'b0;
                        end else begin
                            r_irom_a <= r_irom_a + A_ONE;
                        end
                    end
                end
                default: r_cap_vld <= 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // IRAM stream. Address and data are registered together, so IRAM_D always
    // matches the buffer entry at IRAM_A.
    // -------------------------------------------------------------------------
    assign w_iram_a_next = r_iram_a + A_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iram_valid <= 1'b0;
            r_iram_a     <= '0;
            r_iram_d     <= '0;
        end else begin
            case (r_state)
                S_CMD, S_DONE: begin
                    if (w_accept && (cmd == 4'd0)) begin
                        r_iram_valid <= 1'b1;
                        r_iram_a     <= '0;
                        r_iram_d     <= r_pix[0];
                    end
                end
                S_WRITE: begin
                    if (r_iram_a == LAST_A) begin
                        r_iram_valid <= 1'b0;
                    end else begin
                        r_iram_a <= w_iram_a_next;
                        r_iram_d <= r_pix[w_iram_a_next];
                    end
                end
                default: r_iram_valid <= 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign IROM_rd    = r_irom_rd;
    assign IROM_A     = r_irom_a;
    assign IRAM_valid = r_iram_valid;
    assign IRAM_D     = r_iram_d;
    assign IRAM_A     = r_iram_a;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// -----------------------------------------------------------------------------
// Testbench for lcd_ctrl_param.
// The stimulus side issues commands and updates a behavioural image model.
// A Write pushes the expected frame into a scoreboard queue. Monitor processes
// compare the IRAM stream, the done pulse and the IROM address sequence.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl_param;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PW = 8;
    localparam int AW = 6;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    cmd = 4'd0;
    logic          cmd_valid = 1'b0;
    logic [PW-1:0] IROM_Q = '0;
    logic          IROM_rd;
    logic [AW-1:0] IROM_A;
    logic          IRAM_valid;
    logic [PW-1:0] IRAM_D;
    logic [AW-1:0] IRAM_A;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    lcd_ctrl_param #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_Q     (IROM_Q),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IRAM_valid (IRAM_valid),
        .IRAM_D     (IRAM_D),
        .IRAM_A     (IRAM_A),
        .busy       (busy),
        .done       (done)
    );

    int checks   = 0;
    int failures = 0;

    // ROM contents and behavioural image model
    int rom   [N];
    int m_pix [N];
    int mx, my;

    typedef struct {
        int addr;
        int data;
        bit last;
    } exp_t;
    exp_t sb_q [$];
    exp_t mon_e;
    bit   exp_done = 1'b0;
    int   rom_exp_addr = 0;
    int   rd_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ROM with one cycle read latency
    always @(posedge clk) begin
        if (IROM_rd) IROM_Q <= PW'(rom[IROM_A]);
    end

    // IROM address sequence monitor
    always @(negedge clk) begin
        if (reset_n && IROM_rd) begin
            check("irom_addr", int'(IROM_A), rom_exp_addr);
            rom_exp_addr++;
            rd_cnt++;
        end
    end

    // IRAM scoreboard and done-pulse monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (done || exp_done) check("done_pulse", int'(done), int'(exp_done));
            exp_done = 1'b0;
            if (IRAM_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL iram_unexpected actual=A%0d/D%0d required=no write", IRAM_A, IRAM_D);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("iram_addr", int'(IRAM_A), mon_e.addr);
                    check("iram_data", int'(IRAM_D), mon_e.data);
                    $display("write A=%0d D=%0d exp=%0d", IRAM_A, IRAM_D, mon_e.data);
                    if (mon_e.last) exp_done = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- model
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int min4(input int a, input int b, input int c, input int d);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        if (d < m) m = d;
        return m;
    endfunction

    function automatic void model_apply(input int c);
        int lu, ru, ld, rd, a, b, e, d, v;
        lu = (my - 1) * W + (mx - 1);
        ru = (my - 1) * W + mx;
        ld = my * W + (mx - 1);
        rd = my * W + mx;
        a = m_pix[lu]; b = m_pix[ru]; e = m_pix[ld]; d = m_pix[rd];
        case (c)
            1: if (my > 1) my--;
            2: if (my < H - 1) my++;
            3: if (mx > 1) mx--;
            4: if (mx < W - 1) mx++;
            5, 6, 7: begin
                if (c == 5) v = max4(a, b, e, d);
                else if (c == 6) v = min4(a, b, e, d);
                else v = (a + b + e + d) / 4;
                m_pix[lu] = v; m_pix[ru] = v; m_pix[ld] = v; m_pix[rd] = v;
            end
            8: begin m_pix[lu] = b; m_pix[ld] = a; m_pix[rd] = e; m_pix[ru] = d; end
            9: begin m_pix[ru] = a; m_pix[rd] = b; m_pix[ld] = d; m_pix[lu] = e; end
            10: begin m_pix[lu] = e; m_pix[ld] = a; m_pix[ru] = d; m_pix[rd] = b; end
            11: begin m_pix[lu] = b; m_pix[ru] = a; m_pix[ld] = d; m_pix[rd] = e; end
            default: ;
        endcase
    endfunction

    function automatic void push_frame();
        exp_t e;
        for (int a = 0; a < N; a++) begin
            e.addr = a;
            e.data = m_pix[a];
            e.last = (a == N - 1);
            sb_q.push_back(e);
        end
    endfunction

    function automatic void rom_random(input bit with_window);
        for (int a = 0; a < N; a++) rom[a] = int'($urandom_range(0, 255));
        if (with_window) begin
            rom[27] = 10; rom[28] = 20; rom[35] = 30; rom[36] = 41;
        end
    endfunction

    // ------------------------------------------------------------ stimulus
    task automatic stop_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check_reset_vals();
        check("rst_irom_rd", int'(IROM_rd), 0);
        check("rst_irom_a", int'(IROM_A), 0);
        check("rst_iram_valid", int'(IRAM_valid), 0);
        check("rst_iram_d", int'(IRAM_D), 0);
        check("rst_iram_a", int'(IRAM_A), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done), 0);
    endtask

    // Called at a negedge while reset_n is low; returns at the first CMD negedge
    task automatic release_and_load();
        int k_ready = -1;
        sb_q.delete();
        exp_done = 1'b0;
        rom_exp_addr = 0;
        rd_cnt = 0;
        for (int a = 0; a < N; a++) m_pix[a] = rom[a];
        mx = W / 2;
        my = H / 2;
        reset_n = 1'b1;
        for (int k = 1; k <= N + 20; k++) begin
            @(negedge clk);
            if (!busy) begin
                k_ready = k;
                break;
            end
        end
        if (k_ready < 0) stop_timeout("load_ready");
        check("first_ready_cycle", k_ready, N + 2);
        check("load_rd_count", rd_cnt, N);
        $display("load done: ready after %0d cycles, %0d reads", k_ready, rd_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd = 4'd0;
        #1;
        check_reset_vals();
        @(negedge clk);
        release_and_load();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        stop_timeout("wait_ready");
    endtask

    task automatic issue(input int c);
        wait_ready();
        cmd = 4'(c);
        cmd_valid = 1'b1;
        if (c == 0) push_frame();
        else model_apply(c);
        $display("cmd %0d -> point (%0d,%0d)", c, mx, my);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Write the frame. With hold5, cmd=5 is offered through the write.
    // It must take effect exactly once, in the DONE cycle.
    task automatic write_frame(input bit hold5);
        int k = 1;
        issue(0);
        if (hold5) begin
            cmd = 4'd5;
            cmd_valid = 1'b1;
        end
        while (!done && k < N + 20) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", k, N + 1);
        if (hold5) begin
            model_apply(5);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("busy_after_done_accept", int'(busy), 1);
        end
    endtask

    initial begin
        int c, found;

        // Identity ROM: IRAM_D must equal IRAM_A
        for (int a = 0; a < N; a++) rom[a] = a;
        do_reset();
        write_frame(1'b0);

        // Window arithmetic at (4,4): pixels 27,28,35,36 = 10,20,30,41
        rom_random(1'b1); do_reset(); issue(7); write_frame(1'b0);
        rom_random(1'b1); do_reset(); issue(5); write_frame(1'b0);
        rom_random(1'b1); do_reset(); issue(6); write_frame(1'b0);
        rom_random(1'b1); do_reset(); issue(9); write_frame(1'b0);
        issue(8); write_frame(1'b0);

        // Saturation of the point at every edge
        repeat (8) issue(1);
        issue(11); write_frame(1'b0);
        repeat (8) issue(4);
        issue(10); write_frame(1'b0);
        repeat (8) issue(2);
        repeat (8) issue(3);
        issue(9); write_frame(1'b0);

        // cmd_valid held: one accept per ready cycle, ignored while busy
        rom_random(1'b0); do_reset();
        wait_ready();
        cmd = 4'd3;
        cmd_valid = 1'b1;
        repeat (3) model_apply(3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("held_busy", int'(busy), (i % 2 == 0) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        issue(10);
        write_frame(1'b1);
        write_frame(1'b0);

        // Randomized command mix
        rom_random(1'b0); do_reset();
        for (int i = 0; i < 40; i++) begin
            c = int'($urandom_range(0, 15));
            if (c == 0) write_frame(1'b0);
            else issue(c);
        end
        write_frame(1'b0);

        // Asynchronous reset in the middle of a write
        issue(0);
        found = 0;
        for (int i = 0; i < N + 20; i++) begin
            if (IRAM_valid && IRAM_A == AW'(20)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (found == 0) stop_timeout("abort_point");
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        rom_random(1'b0);
        @(negedge clk);
        release_and_load();
        issue(7);
        write_frame(1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
